if_id_pipe: RTL
===============

IF_ID_PIPE -- requirements
Module: if_id_pipe

Interface
REQ-001 Parameter PC_W, default 32: width of the PC and PC+4 fields.
REQ-002 Parameter INST_W, default 32: width of the instruction word.
REQ-003 Parameter CNT_W, default 16: width of each performance counter.
REQ-004 Parameter NOP_INST, default 32'h0000_0013: instruction presented while the stage holds a bubble.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 PC_out  in  PC_W  IF-stage PC.
REQ-008 PCadd4_Out  in  PC_W  IF-stage PC+4.
REQ-009 im_rdata  in  INST_W  synchronous IM read data, valid in the cycle after the PC was presented.
REQ-010 IF_ID_write  in  1  1 = advance, 0 = stall (hold).
REQ-011 IF_flush  in  1  1 = squash the instruction entering ID.
REQ-012 ID_PC_out  out  PC_W  registered PC.
REQ-013 ID_PCadd4_Out  out  PC_W  registered PC+4.
REQ-014 ID_inst  out  INST_W  instruction for ID, stall-safe.
REQ-015 ID_valid  out  1  1 = ID holds a real instruction.
REQ-016 IF_flush_out  out  1  registered copy of IF_flush.
REQ-017 stall_cnt  out  CNT_W  count of stall cycles.
REQ-018 flush_cnt  out  CNT_W  count of flush cycles.

Function
REQ-019 Priority at each edge SHALL be: flush > stall > advance.
REQ-020 Flush: ID_PC_out and ID_PCadd4_Out SHALL load 0, ID_valid SHALL load 0, and the FSM SHALL enter PASS.
REQ-021 Advance (IF_ID_write=1, IF_flush=0): the PC fields SHALL load their inputs, ID_valid SHALL load 1, and the FSM SHALL enter PASS.
REQ-022 Stall (IF_ID_write=0, IF_flush=0): the PC fields and ID_valid SHALL hold their values.
REQ-023 The FSM SHALL have two states. PASS: ID_inst = im_rdata (combinational). HOLD: ID_inst = hold_buf.
REQ-024 Transition PASS->HOLD on a stall edge; on that edge hold_buf SHALL capture im_rdata, which is the instruction belonging to ID_PC_out.
REQ-025 In HOLD, a stall edge SHALL keep the state and SHALL NOT rewrite hold_buf.
REQ-026 HOLD->PASS on an advance or flush edge.
REQ-027 When ID_valid=0, ID_inst SHALL equal NOP_INST regardless of FSM state.
REQ-028 IF_flush_out SHALL equal IF_flush registered, one cycle of latency, in every mode including stall.
REQ-029 stall_cnt SHALL increment on each stall edge and flush_cnt on each flush edge; both SHALL saturate at all-ones without wrapping.
REQ-030 With flush and stall asserted together, only flush_cnt SHALL increment.

Reset
REQ-031 On rst: ID_PC_out=0, ID_PCadd4_Out=0, ID_valid=0, IF_flush_out=0, FSM=PASS, hold_buf=0, stall_cnt=0, flush_cnt=0; ID_inst therefore equals NOP_INST.
REQ-032 rst asserted mid-HOLD SHALL take effect immediately, without waiting for a clock edge.
REQ-033 The first edge after rst deasserts SHALL follow REQ-019.

Structure
REQ-034 NOP_INST and the FSM state enum (PASS, HOLD) SHALL live in the shared defines package; the widths SHALL reuse the existing PC/word width macros as parameter defaults.
REQ-035 The saturating counter SHALL be one sub-module, sat_counter (params W; ports clk, rst, inc, cnt), instantiated twice.

Verification
REQ-036 Advance with PC_out=0x100, PCadd4_Out=0x104 -> next cycle ID_PC_out=0x100, ID_PCadd4_Out=0x104, ID_valid=1; im_rdata=0x00A00093 -> ID_inst=0x00A00093.
REQ-037 Stall 3 cycles with im_rdata changing to 0xDEADBEEF after the first stall edge -> ID_inst stays 0x00A00093, ID_PC_out stays 0x100, stall_cnt=3.
REQ-038 IF_flush=1 together with IF_ID_write=0 -> next cycle ID_valid=0, ID_PC_out=0, ID_inst=0x00000013, IF_flush_out=1, flush_cnt=1, stall_cnt unchanged.
REQ-039 rst pulsed mid-HOLD between clock edges -> all outputs reach their reset values immediately; ID_inst=0x00000013.
REQ-040 CNT_W=4 with 20 consecutive stall cycles -> stall_cnt=15 and holds at 15.
REQ-041 HOLD, then advance with PC_out=0x200 -> next cycle FSM=PASS, ID_PC_out=0x200, ID_inst tracks im_rdata.

Source files
------------

// File: rtl/if_id_pipe_pkg.sv
// Shared definitions for the IF/ID pipeline register: the default widths,
// the bubble instruction and the instruction-hold FSM encoding.
package if_id_pipe_pkg;

  localparam int PC_WIDTH   = 32;
  localparam int WORD_WIDTH = 32;

  // Encoding of addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [0:0] {
    PASS = 1'b0,
    HOLD = 1'b1
  } fsm_e;

endpackage

// File: rtl/if_id_pipe_if.sv
// Signal bundle between the IF stage (master) and the IF/ID pipeline register (slave).
interface if_id_pipe_if #(
  parameter int PC_W   = if_id_pipe_pkg::PC_WIDTH,
  parameter int INST_W = if_id_pipe_pkg::WORD_WIDTH,
  parameter int CNT_W  = 16
);

  logic [PC_W-1:0]   PC_out;
  logic [PC_W-1:0]   PCadd4_Out;
  logic [INST_W-1:0] im_rdata;
  logic              IF_ID_write;
  logic              IF_flush;

  logic [PC_W-1:0]   ID_PC_out;
  logic [PC_W-1:0]   ID_PCadd4_Out;
  logic [INST_W-1:0] ID_inst;
  logic              ID_valid;
  logic              IF_flush_out;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output PC_out, PCadd4_Out, im_rdata, IF_ID_write, IF_flush,
    input  ID_PC_out, ID_PCadd4_Out, ID_inst, ID_valid, IF_flush_out,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  PC_out, PCadd4_Out, im_rdata, IF_ID_write, IF_flush,
    output ID_PC_out, ID_PCadd4_Out, ID_inst, ID_valid, IF_flush_out,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/if_id_pipe_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = W'(1'b1);
  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count, frozen once saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with flush/stall control and a stall-safe copy of
// the synchronous instruction-memory read data.
module if_id_pipe #(
  parameter int                PC_W     = if_id_pipe_pkg::PC_WIDTH,
  parameter int                INST_W   = if_id_pipe_pkg::WORD_WIDTH,
  parameter int                CNT_W    = 16,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(if_id_pipe_pkg::NOP_INST)
) (
  input logic          clk,
  input logic          rst,
  if_id_pipe_if.slave  bus
);

  import if_id_pipe_pkg::*;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   pc4_q, pc4_d;
  logic              valid_q, valid_d;
  fsm_e              state_q, state_d;
  logic [INST_W-1:0] hold_q, hold_d;
  logic              flush_out_q, flush_out_d;
  logic              stall_inc_s;
  logic              flush_inc_s;

  assign flush_inc_s = bus.IF_flush;
  assign stall_inc_s = ~bus.IF_flush & ~bus.IF_ID_write;

  // next-state: flush beats stall, stall beats advance
  always_comb begin
    pc_d        = pc_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    state_d     = state_q;
    hold_d      = hold_q;
    flush_out_d = bus.IF_flush;
    if (bus.IF_flush) begin
      pc_d    = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
      state_d = PASS;
    end else if (bus.IF_ID_write) begin
      pc_d    = bus.PC_out;
      pc4_d   = bus.PCadd4_Out;
      valid_d = 1'b1;
      state_d = PASS;
    end else begin
      // im_rdata still belongs to ID_PC_out only on the first stall edge
      if (state_q == PASS) begin
        hold_d  = bus.im_rdata;
        state_d = HOLD;
      end else begin
        hold_d  = hold_q;
        state_d = HOLD;
      end
    end
  end

  // pipeline and FSM registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= '0;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
      state_q     <= PASS;
      hold_q      <= '0;
      flush_out_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      flush_out_q <= flush_out_d;
    end
  end

  // a bubble always presents NOP, whatever the FSM holds
  always_comb begin
    bus.ID_inst = NOP_INST;
    if (!valid_q) begin
      bus.ID_inst = NOP_INST;
    end else if (state_q == HOLD) begin
      bus.ID_inst = hold_q;
    end else begin
      bus.ID_inst = bus.im_rdata;
    end
  end

  assign bus.ID_PC_out     = pc_q;
  assign bus.ID_PCadd4_Out = pc4_q;
  assign bus.ID_valid      = valid_q;
  assign bus.IF_flush_out  = flush_out_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc_s),
    .cnt (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc_s),
    .cnt (bus.flush_cnt)
  );

endmodule
